// File: rtl/kyber_ctrl_pkg.sv
// Shared types and defaults for the Kyber add/sub command scheduler.
package kyber_ctrl_pkg;

  localparam int POLY_WORDS = 32;
  localparam int MAX_K      = 4;
  localparam int TIMEOUT    = 80;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LAUNCH,
    RUN,
    SETTLE,
    FINISH
  } sched_state_t;

  typedef struct packed {
    logic       op;
    logic [7:0] base_a;
    logic [7:0] base_b;
    logic [2:0] k;
  } addsub_cmd_t;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/addsub_sched_if.sv
// Requester and engine signals of the add/sub scheduler; slave is the scheduler view.
interface addsub_sched_if;
  logic [1:0] req;
  logic [1:0] req_add;
  logic [7:0] req_base_a0;
  logic [7:0] req_base_a1;
  logic [7:0] req_base_b0;
  logic [7:0] req_base_b1;
  logic [2:0] req_k0;
  logic [2:0] req_k1;
  logic [1:0] ack;
  logic [1:0] done;
  logic       err;
  logic       busy;
  logic       eng_start;
  logic       eng_add_flag;
  logic [7:0] eng_offset_a;
  logic [7:0] eng_offset_b;
  logic       eng_w_en;

  modport master (
    output req, req_add, req_base_a0, req_base_a1, req_base_b0, req_base_b1,
           req_k0, req_k1, eng_w_en,
    input  ack, done, err, busy, eng_start, eng_add_flag, eng_offset_a, eng_offset_b
  );

  modport slave (
    input  req, req_add, req_base_a0, req_base_a1, req_base_b0, req_base_b1,
           req_k0, req_k1, eng_w_en,
    output ack, done, err, busy, eng_start, eng_add_flag, eng_offset_a, eng_offset_b
  );
endinterface

// File: rtl/addsub_sched_rr_arbiter2.sv
// Two-way round-robin arbiter; the requester that did not finish last wins a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_owner,
  output logic [1:0] o_grant
);

  logic r_last;
  logic [1:0] w_grant;

  // NOTE: async active-low reset; sequential state uses non-blocking (<=) only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_last <= 1'b1;
    else if (i_update) r_last <= i_owner;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_grant = i_req;
    if (&i_req) w_grant = r_last ? 2'b01 : 2'b10;
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/addsub_sched.sv
// Grants add/sub vector commands, launches the engine once per polynomial, reports done/err.
module addsub_sched #(
  parameter int POLY_WORDS = kyber_ctrl_pkg::POLY_WORDS,
  parameter int MAX_K      = kyber_ctrl_pkg::MAX_K,
  parameter int TIMEOUT    = kyber_ctrl_pkg::TIMEOUT
) (
  input logic           clk,
  input logic           rst,
  addsub_sched_if.slave bus
);
  import kyber_ctrl_pkg::*;

  localparam int WCNT_W = $clog2(POLY_WORDS + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  sched_state_t      r_state;
  addsub_cmd_t       r_cmd;
  addsub_cmd_t       w_cmd;
  logic              r_owner;
  logic [1:0]        r_ack;
  logic [1:0]        r_done;
  logic              r_err;
  logic              r_busy;
  logic              r_eng_start;
  logic [7:0]        r_off_a;
  logic [7:0]        r_off_b;
  logic [2:0]        r_poly_idx;
  logic [WCNT_W-1:0] r_wcnt;
  logic [TCNT_W-1:0] r_tcnt;

  logic [1:0] w_grant;
  logic       w_arb_update;
  logic       w_k_legal;
  logic       w_last_word;
  logic       w_last_poly;
  logic       w_timeout;
  logic [7:0] w_stride;

  assign w_arb_update = (r_state == FINISH);

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (bus.req),
    .i_update (w_arb_update),
    .i_owner  (r_owner),
    .o_grant  (w_grant)
  );

  // Live fields of the granted requester, valid while ack is high.
  assign w_cmd.op     = bus.req_add[r_owner];
  assign w_cmd.base_a = r_owner ? bus.req_base_a1 : bus.req_base_a0;
  assign w_cmd.base_b = r_owner ? bus.req_base_b1 : bus.req_base_b0;
  assign w_cmd.k      = r_owner ? bus.req_k1      : bus.req_k0;

  assign w_k_legal   = (w_cmd.k != 3'd0) && (int'(w_cmd.k) <= MAX_K);
  assign w_last_word = bus.eng_w_en && (r_wcnt == WCNT_W'(POLY_WORDS - 1));
  assign w_last_poly = (r_poly_idx == r_cmd.k - 3'd1);
  assign w_timeout   = (r_tcnt == TCNT_W'(TIMEOUT - 1));
  assign w_stride    = 8'(POLY_WORDS * int'(r_poly_idx));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_owner     <= 1'b0;
      r_ack       <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_eng_start <= 1'b0;
      r_off_a     <= '0;
      r_off_b     <= '0;
      r_poly_idx  <= '0;
      r_wcnt      <= '0;
      r_tcnt      <= '0;
    end else begin
      r_ack       <= '0;
      r_done      <= '0;
      r_eng_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_state <= GRANT;
            r_ack   <= w_grant;
            r_owner <= w_grant[1];
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        GRANT: begin
          r_cmd      <= w_cmd;
          r_poly_idx <= '0;
          r_wcnt     <= '0;
          if (w_k_legal) begin
            r_state     <= LAUNCH;
            r_eng_start <= 1'b1;
            r_off_a     <= w_cmd.base_a;
            r_off_b     <= w_cmd.base_b;
          end else begin
            r_state <= FINISH;
            r_err   <= 1'b1;
            r_done  <= owner_onehot(r_owner);
          end
        end
        LAUNCH: begin
          r_tcnt  <= '0;
          r_state <= RUN;
        end
        RUN: begin
          // A completing write wins over a timeout landing in the same cycle.
          if (w_last_word) begin
            r_wcnt <= '0;
            if (w_last_poly) begin
              r_state <= FINISH;
              r_done  <= owner_onehot(r_owner);
            end else begin
              r_poly_idx <= r_poly_idx + 3'd1;
              r_state    <= SETTLE;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= FINISH;
            r_done  <= owner_onehot(r_owner);
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
            if (bus.eng_w_en) r_wcnt <= r_wcnt + 1'b1;
          end
        end
        SETTLE: begin
          r_state     <= LAUNCH;
          r_eng_start <= 1'b1;
          r_off_a     <= r_cmd.base_a + w_stride;
          r_off_b     <= r_cmd.base_b + w_stride;
        end
        FINISH: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack          = r_ack;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.busy         = r_busy;
  assign bus.eng_start    = r_eng_start;
  assign bus.eng_add_flag = r_cmd.op;
  assign bus.eng_offset_a = r_off_a;
  assign bus.eng_offset_b = r_off_b;

endmodule

// File: tb/tb_addsub_sched.sv
// Directed bench for addsub_sched with a lane-wise mod-3329 engine model.
module tb_addsub_sched;
  import kyber_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  addsub_sched_if bus ();

  addsub_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    logic [1:0] v;
    logic [7:0] a;
    logic [7:0] b;
    logic       f;
  } ev_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_low_cyc = -1;
  logic prev_busy = 1'b0;
  ev_t  q_ack[$];
  ev_t  q_done[$];
  ev_t  q_start[$];

  int         eng_max = 32;
  int         e_cnt = -1;
  logic [7:0] e_a, e_b;
  logic       e_add;
  logic [11:0] mem [256][8];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Event recorder; also models requesters dropping req on their ack.
  initial forever begin
    @(negedge clk);
    if (bus.ack != 2'b00) begin
      q_ack.push_back('{cyc, bus.ack, 8'h00, 8'h00, bus.err});
      if (bus.ack[0]) bus.req[0] = 1'b0;
      if (bus.ack[1]) bus.req[1] = 1'b0;
    end
    if (bus.done != 2'b00) q_done.push_back('{cyc, bus.done, 8'h00, 8'h00, bus.err});
    if (bus.eng_start)
      q_start.push_back('{cyc, 2'b00, bus.eng_offset_a, bus.eng_offset_b, bus.eng_add_flag});
    if (prev_busy && !bus.busy) busy_low_cyc = cyc;
    prev_busy = bus.busy;
  end

  task automatic eng_write(input int j);
    logic [7:0] a, b;
    int x, y, r;
    a = e_a + 8'(j);
    b = e_b + 8'(j);
    for (int l = 0; l < 8; l++) begin
      x = int'(mem[a][l]);
      y = int'(mem[b][l]);
      r = e_add ? (x + y) % 3329 : (x - y + 3329) % 3329;
      mem[a][l] = 12'(r);
    end
  endtask

  // Engine: 33 cycles after start, one write per cycle for up to eng_max words.
  initial begin
    bus.eng_w_en = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) e_cnt = -1;
      else if (bus.eng_start) begin
        e_cnt = 0;
        e_a   = bus.eng_offset_a;
        e_b   = bus.eng_offset_b;
        e_add = bus.eng_add_flag;
      end else if (e_cnt >= 0) e_cnt = (e_cnt >= 65) ? -1 : e_cnt + 1;
      if (e_cnt >= 33 && e_cnt < 33 + eng_max) begin
        bus.eng_w_en = 1'b1;
        eng_write(e_cnt - 33);
      end else bus.eng_w_en = 1'b0;
    end
  end

  function automatic ev_t get_ack(input int i);
    ev_t e = '{-1, 2'b00, 8'h00, 8'h00, 1'b0};
    if (i < q_ack.size()) e = q_ack[i];
    return e;
  endfunction

  function automatic ev_t get_done(input int i);
    ev_t e = '{-1, 2'b00, 8'h00, 8'h00, 1'b0};
    if (i < q_done.size()) e = q_done[i];
    return e;
  endfunction

  function automatic ev_t get_start(input int i);
    ev_t e = '{-1, 2'b00, 8'h00, 8'h00, 1'b0};
    if (i < q_start.size()) e = q_start[i];
    return e;
  endfunction

  task automatic init_mem();
    for (int i = 0; i < 256; i++)
      for (int l = 0; l < 8; l++) mem[i][l] = 12'(i * 10 + l);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = 2'b00;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    settle(1);
  endtask

  task automatic issue(input logic [1:0] rq,
                       input logic add0, input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] k0,
                       input logic add1, input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] k1);
    q_ack.delete();
    q_done.delete();
    q_start.delete();
    busy_low_cyc = -1;
    @(posedge clk);
    #1;
    bus.req_add     = {add1, add0};
    bus.req_base_a0 = a0;
    bus.req_base_b0 = b0;
    bus.req_k0      = k0;
    bus.req_base_a1 = a1;
    bus.req_base_b1 = b1;
    bus.req_k1      = k1;
    bus.req         = rq;
    cyc             = 0;
  endtask

  task automatic wait_done(input int n, input int limit, input string name);
    while (q_done.size() < n && cyc < limit) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (q_done.size() < n) begin
      errors++;
      $display("FAIL %s wait: got %0d done pulses by cycle %0d, need %0d", name, q_done.size(), cyc, n);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.ack !== 2'b00 || bus.done !== 2'b00 || bus.err !== 1'b0 || bus.busy !== 1'b0 ||
        bus.eng_start !== 1'b0 || bus.eng_add_flag !== 1'b0 ||
        bus.eng_offset_a !== 8'h00 || bus.eng_offset_b !== 8'h00) begin
      errors++;
      $display("FAIL %s: ack=%b done=%b err=%b busy=%b start=%b flag=%b offa=%h offb=%h, required all 0",
               name, bus.ack, bus.done, bus.err, bus.busy, bus.eng_start, bus.eng_add_flag,
               bus.eng_offset_a, bus.eng_offset_b);
    end
  endtask

  task automatic test_reset();
    #12;
    check_idle_outputs("reset_state");
    do_reset();
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_single_add();
    ev_t e;
    issue(2'b01, 1'b1, 8'h00, 8'h40, 3'd1, 1'b0, 8'h00, 8'h00, 3'd1);
    wait_done(1, 150, "add1");
    settle(2);
    e = get_ack(0);
    checks++;
    if (q_ack.size() !== 1 || e.cyc !== 1 || e.v !== 2'b01) begin
      errors++;
      $display("FAIL add1_ack: n=%0d cyc=%0d val=%b, required n=1 cyc=1 val=01", q_ack.size(), e.cyc, e.v);
    end
    e = get_start(0);
    checks++;
    if (q_start.size() !== 1 || e.cyc !== 2 || e.a !== 8'h00 || e.b !== 8'h40 || e.f !== 1'b1) begin
      errors++;
      $display("FAIL add1_start: n=%0d cyc=%0d a=%h b=%h flag=%b, required n=1 cyc=2 a=00 b=40 flag=1",
               q_start.size(), e.cyc, e.a, e.b, e.f);
    end
    e = get_done(0);
    checks++;
    if (e.cyc !== 67 || e.v !== 2'b01 || e.f !== 1'b0) begin
      errors++;
      $display("FAIL add1_done: cyc=%0d val=%b err=%b, required cyc=67 val=01 err=0", e.cyc, e.v, e.f);
    end
    checks++;
    if (busy_low_cyc !== 68) begin
      errors++;
      $display("FAIL add1_busy_low: cycle %0d, required 68", busy_low_cyc);
    end
  endtask

  task automatic test_sub3();
    ev_t e;
    logic [7:0] exp_a [3] = '{8'h20, 8'h40, 8'h60};
    logic [7:0] exp_b [3] = '{8'h80, 8'hA0, 8'hC0};
    int exp_c [3] = '{2, 68, 134};
    init_mem();
    issue(2'b10, 1'b0, 8'h00, 8'h00, 3'd1, 1'b0, 8'h20, 8'h80, 3'd3);
    wait_done(1, 300, "sub3");
    settle(2);
    checks++;
    if (q_start.size() !== 3) begin
      errors++;
      $display("FAIL sub3_nstart: got %0d starts, required 3", q_start.size());
    end
    for (int i = 0; i < 3; i++) begin
      e = get_start(i);
      checks++;
      if (e.cyc !== exp_c[i] || e.a !== exp_a[i] || e.b !== exp_b[i] || e.f !== 1'b0) begin
        errors++;
        $display("FAIL sub3_start%0d: cyc=%0d a=%h b=%h flag=%b, required cyc=%0d a=%h b=%h flag=0",
                 i, e.cyc, e.a, e.b, e.f, exp_c[i], exp_a[i], exp_b[i]);
      end
    end
    e = get_done(0);
    checks++;
    if (e.cyc !== 199 || e.v !== 2'b10 || e.f !== 1'b0) begin
      errors++;
      $display("FAIL sub3_done: cyc=%0d val=%b err=%b, required cyc=199 val=10 err=0", e.cyc, e.v, e.f);
    end
    checks++;
    if (mem[8'h20][0] !== 12'd2369) begin
      errors++;
      $display("FAIL sub3_mem20: got %0d, required 2369", mem[8'h20][0]);
    end
  endtask

  task automatic test_tie();
    ev_t e0, e1, d0, d1;
    do_reset();
    issue(2'b11, 1'b1, 8'h00, 8'h40, 3'd1, 1'b1, 8'h80, 8'hC0, 3'd1);
    wait_done(2, 300, "tie");
    e0 = get_ack(0);
    e1 = get_ack(1);
    d0 = get_done(0);
    d1 = get_done(1);
    checks++;
    if (e0.cyc !== 1 || e0.v !== 2'b01 || d0.cyc !== 67 || d0.v !== 2'b01) begin
      errors++;
      $display("FAIL tie_first: ack cyc=%0d val=%b done cyc=%0d val=%b, required 1/01 and 67/01",
               e0.cyc, e0.v, d0.cyc, d0.v);
    end
    checks++;
    if (e1.cyc !== 69 || e1.v !== 2'b10 || d1.cyc !== 135 || d1.v !== 2'b10) begin
      errors++;
      $display("FAIL tie_second: ack cyc=%0d val=%b done cyc=%0d val=%b, required 69/10 and 135/10",
               e1.cyc, e1.v, d1.cyc, d1.v);
    end
    issue(2'b11, 1'b1, 8'h00, 8'h40, 3'd1, 1'b1, 8'h80, 8'hC0, 3'd1);
    wait_done(2, 300, "tie3");
    e0 = get_ack(0);
    checks++;
    if (e0.cyc !== 1 || e0.v !== 2'b01) begin
      errors++;
      $display("FAIL tie_third: ack cyc=%0d val=%b, required cyc=1 val=01", e0.cyc, e0.v);
    end
  endtask

  task automatic test_wrap();
    ev_t e;
    init_mem();
    issue(2'b01, 1'b1, 8'hE0, 8'hF0, 3'd2, 1'b0, 8'h00, 8'h00, 3'd1);
    wait_done(1, 250, "wrap");
    settle(2);
    e = get_start(1);
    checks++;
    if (e.cyc !== 68 || e.a !== 8'h00 || e.b !== 8'h10) begin
      errors++;
      $display("FAIL wrap_start1: cyc=%0d a=%h b=%h, required cyc=68 a=00 b=10", e.cyc, e.a, e.b);
    end
    e = get_done(0);
    checks++;
    if (e.cyc !== 133 || e.v !== 2'b01) begin
      errors++;
      $display("FAIL wrap_done: cyc=%0d val=%b, required cyc=133 val=01", e.cyc, e.v);
    end
    checks++;
    if (mem[8'hE0][0] !== 12'd1311 || mem[8'hFF][7] !== 12'd2714 || mem[8'h00][3] !== 12'd166 ||
        mem[8'h10][0] !== 12'd480 || mem[8'h1F][5] !== 12'd790) begin
      errors++;
      $display("FAIL wrap_mem: E0.0=%0d FF.7=%0d 00.3=%0d 10.0=%0d 1F.5=%0d, required 1311 2714 166 480 790",
               mem[8'hE0][0], mem[8'hFF][7], mem[8'h00][3], mem[8'h10][0], mem[8'h1F][5]);
    end
  endtask

  task automatic test_timeout();
    ev_t e;
    eng_max = 10;
    issue(2'b01, 1'b1, 8'h00, 8'h40, 3'd1, 1'b0, 8'h00, 8'h00, 3'd1);
    wait_done(1, 200, "timeout");
    settle(3);
    e = get_done(0);
    checks++;
    if (e.cyc !== 83 || e.v !== 2'b01 || e.f !== 1'b1) begin
      errors++;
      $display("FAIL timeout_done: cyc=%0d val=%b err=%b, required cyc=83 val=01 err=1", e.cyc, e.v, e.f);
    end
    checks++;
    if (busy_low_cyc !== 84 || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_idle: busy low cycle %0d err=%b, required 84 and err=1", busy_low_cyc, bus.err);
    end
    eng_max = 32;
    issue(2'b01, 1'b1, 8'h00, 8'h40, 3'd1, 1'b0, 8'h00, 8'h00, 3'd1);
    wait_done(1, 150, "timeout_recover");
    e = get_ack(0);
    checks++;
    if (e.cyc !== 1 || e.f !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_clear: ack cyc=%0d err=%b, required cyc=1 err=0", e.cyc, e.f);
    end
    e = get_done(0);
    checks++;
    if (e.cyc !== 67 || e.f !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover_done: cyc=%0d err=%b, required cyc=67 err=0", e.cyc, e.f);
    end
  endtask

  task automatic test_illegal_k();
    ev_t a, d;
    logic [2:0] bad_k [2] = '{3'd0, 3'd5};
    logic [1:0] who [2] = '{2'b01, 2'b10};
    for (int i = 0; i < 2; i++) begin
      issue(who[i], 1'b1, 8'h10, 8'h20, bad_k[i], 1'b1, 8'h10, 8'h20, bad_k[i]);
      wait_done(1, 20, "illegal_k");
      settle(4);
      a = get_ack(0);
      d = get_done(0);
      checks++;
      if (a.cyc !== 1 || a.v !== who[i] || d.cyc !== 2 || d.v !== who[i] || d.f !== 1'b1) begin
        errors++;
        $display("FAIL illegal_k%0d: ack %0d/%b done %0d/%b err=%b, required ack 1/%b done 2/%b err=1",
                 bad_k[i], a.cyc, a.v, d.cyc, d.v, d.f, who[i], who[i]);
      end
      checks++;
      if (q_start.size() !== 0 || busy_low_cyc !== 3) begin
        errors++;
        $display("FAIL illegal_k%0d_nolaunch: starts=%0d busy low %0d, required 0 starts busy low 3",
                 bad_k[i], q_start.size(), busy_low_cyc);
      end
    end
  endtask

  task automatic test_midrun_reset();
    ev_t e;
    issue(2'b01, 1'b1, 8'h00, 8'h40, 3'd1, 1'b0, 8'h00, 8'h00, 3'd1);
    while (cyc < 40) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("midrun_reset_outputs");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    settle(80);
    checks++;
    if (q_done.size() !== 0) begin
      errors++;
      $display("FAIL midrun_no_done: got %0d done pulses, required 0", q_done.size());
    end
    issue(2'b01, 1'b1, 8'h00, 8'h40, 3'd1, 1'b0, 8'h00, 8'h00, 3'd1);
    wait_done(1, 150, "post_reset");
    e = get_start(0);
    checks++;
    if (e.cyc !== 2 || e.a !== 8'h00 || e.b !== 8'h40 || e.f !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_start: cyc=%0d a=%h b=%h flag=%b, required cyc=2 a=00 b=40 flag=1",
               e.cyc, e.a, e.b, e.f);
    end
    e = get_done(0);
    checks++;
    if (e.cyc !== 67 || e.v !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_done: cyc=%0d val=%b, required cyc=67 val=01", e.cyc, e.v);
    end
  endtask

  initial begin
    bus.req         = 2'b00;
    bus.req_add     = 2'b00;
    bus.req_base_a0 = 8'h00;
    bus.req_base_a1 = 8'h00;
    bus.req_base_b0 = 8'h00;
    bus.req_base_b1 = 8'h00;
    bus.req_k0      = 3'd0;
    bus.req_k1      = 3'd0;
    init_mem();
    test_reset();
    test_single_add();
    test_sub3();
    test_tie();
    test_wrap();
    test_timeout();
    test_illegal_k();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
